// File: rtl/maxpool_sequencer_pkg.sv
// rtl/maxpool_sequencer_pkg.sv - shared FP32 types, constants and pooling FSM states
package tpu_fp_pkg;

  typedef struct packed {
    logic        sign;
    logic [7:0]  exp;
    logic [22:0] mant;
  } fp32_t;

  localparam logic [31:0] FP32_CANON_NAN = 32'h7FC0_0000;
  localparam logic [7:0]  FP32_EXP_MAX   = 8'hFF;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } maxpool_state_e;

endpackage

// File: rtl/maxpool_sequencer_if.sv
// rtl/maxpool_sequencer_if.sv - operand/result stream bundle for the max-pool sequencer
interface maxpool_sequencer_if #(
  parameter int MAX_WINDOW = 16
);
  localparam int LEN_W = $clog2(MAX_WINDOW + 1);

  logic [LEN_W-1:0] cfg_len;
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_data;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      out_data;
  logic             busy;
  logic [15:0]      win_count;

  modport master (
    output cfg_len, in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, busy, win_count
  );

  modport slave (
    input  cfg_len, in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, busy, win_count
  );

endinterface

// File: rtl/maxpool_sequencer_fp32_max_cmp.sv
// rtl/maxpool_sequencer_fp32_max_cmp.sv - combinational FP32 max on raw bits (ties keep a)
module fp32_max_cmp
  import tpu_fp_pkg::*;
(
  input  fp32_t a,
  input  fp32_t b,
  output fp32_t y,
  output logic  is_nan_b
);

  logic [30:0] magA;
  logic [30:0] magB;

  assign magA = {a.exp, a.mant};
  assign magB = {b.exp, b.mant};

  // Strict compares so bit-identical operands fall through to a.
  always_comb begin
    y = a;
    if (a.sign != b.sign) begin
      y = a.sign ? b : a;
    end else if (!a.sign) begin
      y = (magB > magA) ? b : a;
    end else begin
      y = (magB < magA) ? b : a;
    end
  end

  assign is_nan_b = (b.exp == FP32_EXP_MAX) && (b.mant != 23'd0);

endmodule

// File: rtl/maxpool_sequencer.sv
// rtl/maxpool_sequencer.sv - streaming FP32 max-pool window reducer
// Optional NaN propagation: MAXPOOL_NAN_PROPAGATE_EN
module maxpool_sequencer
  import tpu_fp_pkg::*;
#(
  parameter int MAX_WINDOW = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  maxpool_sequencer_if.slave  bus
);

  localparam int LEN_W = $clog2(MAX_WINDOW + 1);

  localparam logic [1:0] ST_IDLE  = IDLE;
  localparam logic [1:0] ST_ACCUM = ACCUM;
  localparam logic [1:0] ST_DONE  = DONE;

  logic [1:0]       stateQ;
  fp32_t            accQ;
  logic [LEN_W-1:0] cntQ;
  logic [LEN_W-1:0] lenQ;
  logic [LEN_W-1:0] lenEff;
  logic [15:0]      winCountQ;
  fp32_t            cmpY;
  logic             nanB;
  logic             beat;
  logic             take;

  fp32_max_cmp u_cmp (
    .a        (accQ),
    .b        (fp32_t'(bus.in_data)),
    .y        (cmpY),
    .is_nan_b (nanB)
  );

  always_comb begin
    lenEff = bus.cfg_len;
    if (bus.cfg_len == '0) begin
      lenEff = LEN_W'(1);
    end else if (bus.cfg_len > LEN_W'(MAX_WINDOW)) begin
      lenEff = LEN_W'(MAX_WINDOW);
    end
  end

  // In DONE the next operand can only enter alongside the result leaving.
  assign bus.in_ready  = rst_n && ((stateQ == ST_DONE) ? bus.out_ready : 1'b1);
  assign beat          = bus.in_valid && bus.in_ready;
  assign take          = (stateQ == ST_DONE) && bus.out_ready;
  assign bus.out_valid = (stateQ == ST_DONE);
  assign bus.busy      = (stateQ == ST_ACCUM);
  assign bus.win_count = winCountQ;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stateQ    <= ST_IDLE;
      accQ      <= '0;
      cntQ      <= '0;
      lenQ      <= '0;
      winCountQ <= '0;
    end else begin
      if (take) begin
        winCountQ <= winCountQ + 16'd1;
      end
      case (stateQ)
        ST_IDLE, ST_DONE: begin
          if (beat) begin
            accQ   <= fp32_t'(bus.in_data);
            cntQ   <= LEN_W'(1);
            lenQ   <= lenEff;
            stateQ <= (lenEff == LEN_W'(1)) ? ST_DONE : ST_ACCUM;
          end else if (take) begin
            stateQ <= ST_IDLE;
          end
        end
        ST_ACCUM: begin
          if (beat) begin
            accQ <= cmpY;
            cntQ <= cntQ + LEN_W'(1);
            if ((cntQ + LEN_W'(1)) == lenQ) begin
              stateQ <= ST_DONE;
            end
          end
        end
        default: stateQ <= ST_IDLE;
      endcase
    end
  end

`ifdef MAXPOOL_NAN_PROPAGATE_EN
  logic nanSeenQ;

  // A window's first beat restarts the flag; later beats only accumulate it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      nanSeenQ <= 1'b0;
    end else if (beat) begin
      nanSeenQ <= (stateQ == ST_ACCUM) ? (nanSeenQ | nanB) : nanB;
    end
  end

  assign bus.out_data = nanSeenQ ? FP32_CANON_NAN : accQ;
`else
  logic unusedNanB;
  assign unusedNanB   = nanB;
  assign bus.out_data = accQ;
`endif

endmodule

// File: tb/tb_maxpool_sequencer.sv
// tb/tb_maxpool_sequencer.sv - scoreboard bench for maxpool_sequencer
module tb_maxpool_sequencer;

`ifdef MAXPOOL_NAN_PROPAGATE_EN
  localparam bit NAN_EN = 1'b1;
`else
  localparam bit NAN_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  maxpool_sequencer_if bus ();

  maxpool_sequencer dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int          nChecks = 0;
  int          nFails = 0;
  logic [31:0] sb[$];
  logic [31:0] beatQ[$];
  logic [15:0] tbWins = 16'd0;

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nChecks++;
    if (got !== exp) begin
      nFails++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  // Maps FP32 bits onto an unsigned key whose order is the required max order.
  function automatic logic [31:0] orderKey(input logic [31:0] v);
    return v[31] ? ~v : (v | 32'h8000_0000);
  endfunction

  function automatic logic isNan(input logic [31:0] v);
    return (v[30:23] == 8'hFF) && (v[22:0] != 23'd0);
  endfunction

  always @(negedge clk) begin
    if (!rst_n) begin
      tbWins = 16'd0;
    end else if (bus.out_valid && bus.out_ready) begin
      if (sb.size() == 0) begin
        checkVal("sb_underflow", 32'd1, 32'd0);
      end else begin
        checkVal("out_data", bus.out_data, sb.pop_front());
      end
      checkVal("win_count", 32'(bus.win_count), 32'(tbWins));
      tbWins = tbWins + 16'd1;
    end
  end

  // Callers enter just after a rising edge; the beat is accepted at the first edge with in_ready.
  task automatic sendBeat(input logic [31:0] d, input logic [4:0] len, output int waited);
    logic ok;
    waited = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.cfg_len  = len;
    forever begin
      @(negedge clk);
      ok = bus.in_ready;
      @(posedge clk);
      #1;
      if (ok) break;
      waited++;
      if (waited >= 64) begin
        checkVal("in_timeout", 32'd0, 32'd1);
        break;
      end
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic sendWindow(input logic [4:0] len, output int waits);
    logic [31:0] best;
    logic        anyNan;
    int          w;
    best   = beatQ[0];
    anyNan = 1'b0;
    waits  = 0;
    foreach (beatQ[i]) begin
      if (orderKey(beatQ[i]) > orderKey(best)) best = beatQ[i];
      anyNan = anyNan | isNan(beatQ[i]);
    end
    if (NAN_EN && anyNan) best = 32'h7FC0_0000;
    sb.push_back(best);
    foreach (beatQ[i]) begin
      sendBeat(beatQ[i], (i == 0) ? len : 5'(i + 9), w);
      waits += w;
      if (i < beatQ.size() - 1) begin
        checkVal("mid_busy", 32'(bus.busy), 32'd1);
        checkVal("mid_valid", 32'(bus.out_valid), 32'd0);
      end else begin
        checkVal("last_busy", 32'(bus.busy), 32'd0);
        checkVal("last_valid", 32'(bus.out_valid), 32'd1);
      end
    end
  endtask

  task automatic setBeats(input logic [31:0] a, b, c, d, input int n);
    beatQ.delete();
    beatQ.push_back(a);
    if (n > 1) beatQ.push_back(b);
    if (n > 2) beatQ.push_back(c);
    if (n > 3) beatQ.push_back(d);
  endtask

  task automatic waitDrain();
    int k;
    k = 0;
    while (sb.size() != 0 && k < 64) begin
      @(posedge clk);
      #1;
      k++;
    end
    checkVal("sb_drained", 32'(sb.size()), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    int total;
    int c;
    int eff;

    bus.in_valid  = 1'b0;
    bus.in_data   = 32'd0;
    bus.cfg_len   = 5'd0;
    bus.out_ready = 1'b1;

    repeat (2) @(posedge clk);
    @(negedge clk);
    checkVal("rst_in_ready", 32'(bus.in_ready), 32'd0);
    checkVal("rst_out_valid", 32'(bus.out_valid), 32'd0);
    checkVal("rst_out_data", bus.out_data, 32'd0);
    checkVal("rst_busy", 32'(bus.busy), 32'd0);
    checkVal("rst_win_count", 32'(bus.win_count), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    checkVal("idle_in_ready", 32'(bus.in_ready), 32'd1);
    @(posedge clk);
    #1;

    // len=4 window, result the cycle after the last beat
    setBeats(32'h4040_0000, 32'hBF80_0000, 32'h40F0_0000, 32'h4000_0000, 4);
    sendWindow(5'd4, w);
    checkVal("len4_waits", 32'(w), 32'd0);
    checkVal("len4_data", bus.out_data, 32'h40F0_0000);
    @(posedge clk);
    #1;
    checkVal("len4_win_count", 32'(bus.win_count), 32'd1);
    checkVal("len4_released", 32'(bus.out_valid), 32'd0);

    // all-negative window, then signed zeros both orders, back to back
    total = 0;
    setBeats(32'hC0A0_0000, 32'hBF00_0000, 32'hC000_0000, 32'd0, 3);
    sendWindow(5'd3, w);
    total += w;
    setBeats(32'h8000_0000, 32'h0000_0000, 32'd0, 32'd0, 2);
    sendWindow(5'd2, w);
    total += w;
    setBeats(32'h0000_0000, 32'h8000_0000, 32'd0, 32'd0, 2);
    sendWindow(5'd2, w);
    total += w;
    checkVal("b2b_waits", 32'(total), 32'd0);
    waitDrain();

    // result stalled by downstream, then released together with the next first beat
    bus.out_ready = 1'b0;
    setBeats(32'h3F80_0000, 32'h4000_0000, 32'd0, 32'd0, 2);
    sendWindow(5'd2, w);
    bus.in_valid = 1'b1;
    bus.in_data  = 32'hC000_0000;
    bus.cfg_len  = 5'd2;
    sb.push_back(32'hC000_0000);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checkVal("stall_valid", 32'(bus.out_valid), 32'd1);
      checkVal("stall_data", bus.out_data, 32'h4000_0000);
      checkVal("stall_in_ready", 32'(bus.in_ready), 32'd0);
      @(posedge clk);
      #1;
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    checkVal("resume_in_ready", 32'(bus.in_ready), 32'd1);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    checkVal("resume_busy", 32'(bus.busy), 32'd1);
    sendBeat(32'hC040_0000, 5'd2, w);
    checkVal("resume_valid", 32'(bus.out_valid), 32'd1);
    waitDrain();

    // single-beat windows via cfg_len=1 and cfg_len=0, one result per cycle
    total = 0;
    for (int i = 0; i < 8; i++) begin
      beatQ.delete();
      beatQ.push_back(32'h3F00_0000 + 32'(i * 32'h0011_0000) + ((i % 2 == 1) ? 32'h8000_0000 : 32'd0));
      sendWindow((i < 4) ? 5'd1 : 5'd0, w);
      total += w;
    end
    checkVal("len1_waits", 32'(total), 32'd0);
    waitDrain();

    // reset mid-window discards the partial maximum
    sendBeat(32'h7F00_0000, 5'd4, w);
    sendBeat(32'h7F00_0000, 5'd4, w);
    rst_n = 1'b0;
    @(negedge clk);
    checkVal("midrst_in_ready", 32'(bus.in_ready), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    checkVal("midrst_out_valid", 32'(bus.out_valid), 32'd0);
    checkVal("midrst_win_count", 32'(bus.win_count), 32'd0);
    checkVal("midrst_busy", 32'(bus.busy), 32'd0);
    @(posedge clk);
    #1;
    setBeats(32'h3F80_0000, 32'h4040_0000, 32'h4000_0000, 32'hBF80_0000, 4);
    sendWindow(5'd4, w);
    waitDrain();

    // random windows including out-of-range cfg_len
    for (int n = 0; n < 10; n++) begin
      c   = int'($urandom_range(0, 20));
      eff = (c == 0) ? 1 : ((c > 16) ? 16 : c);
      beatQ.delete();
      for (int k = 0; k < eff; k++) beatQ.push_back($urandom());
      sendWindow(5'(c), w);
    end
    waitDrain();

    // NaN operand: bit-ordered by default, canonical quiet NaN with propagation
    setBeats(32'h3F80_0000, 32'h7F80_0001, 32'h4000_0000, 32'd0, 3);
    sendWindow(5'd3, w);
    waitDrain();

    $display("TB_RESULT checks=%0d failures=%0d", nChecks, nFails);
    $finish;
  end

endmodule

// File: doc/maxpool_sequencer.md
Name: maxpool_sequencer

Overview:
- Streaming max-pooling controller for the TPU vector path.
- Accepts FP32 operands over a valid/ready stream and reduces each window of cfg_len operands to its maximum using a single compare stage.
- Emits one result per window over a valid/ready output stream.
- Sits between the activation buffer read port and the pooled-result writeback.

Parameters:
- MAX_WINDOW, 16, largest supported window length in operands.
- LEN_W, $clog2(MAX_WINDOW+1), width of cfg_len and the internal beat counter (derived; do not override).

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  synchronous active-low reset.
- cfg_len  input  LEN_W  window length; sampled only on the first accepted beat of a window.
- in_valid  input  1  operand valid.
- in_ready  output  1  operand accepted when in_valid && in_ready.
- in_data  input  32  FP32 operand.
- out_valid  output  1  result valid.
- out_ready  input  1  downstream accepts result.
- out_data  output  32  FP32 window maximum.
- busy  output  1  high while a window is partially accumulated (state ACCUM).
- win_count  output  16  count of completed windows; increments on each result handshake; wraps 0xFFFF->0.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-low on rst_n. While rst_n=0 at a clk edge: state<=IDLE, acc<=0, cnt<=0, out_valid=0, out_data=0, busy=0, win_count=0. in_ready is forced to 0 while rst_n=0.
- Effective length: len_eff = 1 if cfg_len==0; MAX_WINDOW if cfg_len>MAX_WINDOW; else cfg_len. It is latched as len_q on the first beat.
- FSM states: IDLE, ACCUM, DONE.
- IDLE:
  - in_ready=1.
  - On a beat: acc<=in_data, cnt<=1, latch len_q.
  - If len_eff==1, go to DONE; else go to ACCUM.
- ACCUM:
  - in_ready=1.
  - On a beat: acc<=fmax(acc,in_data), cnt<=cnt+1.
  - If cnt+1==len_q, go to DONE.
  - No beat: hold all state.
- DONE:
  - out_valid=1, out_data=acc.
  - in_ready=out_ready (combinational).
  - On out_ready: win_count++.
  - If in_valid is also high, that beat starts the next window exactly as in IDLE (goes to ACCUM, or stays in DONE with the new acc if its len_eff==1). Otherwise go to IDLE.
  - Without out_ready: out_data stays stable and no input is accepted.
- Latency and throughput:
  - out_valid rises the cycle after the last beat is accepted.
  - Sustained throughput is one operand per cycle with no bubble between windows, provided out_ready=1.
- fmax(a,b) ordering, applied to raw bits with no normalization, flushing or rounding:
  - Signs differ: the positive operand wins. +0 beats -0.
  - Both positive: the larger unsigned {exp,mant} wins.
  - Both negative: the smaller unsigned {exp,mant} wins.
  - Bit-identical: return a (the accumulator).
  - Denormals are compared by magnitude bits. Inf follows naturally.
  - Without the optional feature, NaN is ordered by its bit pattern, like any other value.
- Reset mid-window discards the partial window and any pending result.
- cfg_len changes mid-window are ignored.

Optional Feature:
- Macro: MAXPOOL_NAN_PROPAGATE_EN.
- Defined:
  - A sticky nan_seen flag is set by any operand with exp==0xFF and mant!=0. It is cleared on the first beat of each new window.
  - If set when the window completes, out_data=0x7FC00000 (canonical quiet NaN).
- Undefined: no flag; NaNs are ordered by bit pattern per fmax.

Decomposition:
- Shared package tpu_fp_pkg holds:
  - typedef fp32_t, a packed struct {sign, exp[7:0], mant[22:0]};
  - the constants FP32_CANON_NAN=32'h7FC00000 and FP32_EXP_MAX=8'hFF;
  - enum maxpool_state_e {IDLE, ACCUM, DONE}.
- One sub-module, fp32_max_cmp: purely combinational. Inputs a and b (fp32_t); outputs y (fp32_t) and is_nan_b. Implements fmax exactly. Used once, on the accumulator path.

Test Plan:
- len=4, beats 0x40400000, 0xBF800000, 0x40F00000, 0x40000000 with out_ready=1 -> out_valid the cycle after beat 4, out_data=0x40F00000, win_count=1.
- len=3, beats 0xC0A00000, 0xBF000000, 0xC0000000 -> out_data=0xBF000000.
- len=2, beats 0x80000000 then 0x00000000 -> 0x00000000; reversed order -> 0x00000000.
- out_ready=0 for 5 cycles after completion -> out_valid held, out_data stable, in_ready=0. Then raise out_ready with in_valid=1 in the same cycle -> result taken and new window's first beat accepted, no beat lost or duplicated.
- cfg_len=1, then cfg_len=0, with continuous in_valid and out_ready=1 -> one result per cycle, each equal to its input; busy stays 0.
- rst_n=0 for one cycle after 2 beats of a len=4 window -> out_valid=0, win_count=0. The next 4 beats form a fresh window whose maximum excludes the discarded beats.
- With MAXPOOL_NAN_PROPAGATE_EN defined, len=3 beats 0x3F800000, 0x7F800001, 0x40000000 -> 0x7FC00000. Without the macro -> 0x7F800001.
